// File: rtl/fp_exponent_adjust.sv
// Biased-exponent path of the FP multiplier: exp_a + exp_b - BIAS + norm_inc,
// classified for zero/inf/invalid/overflow/underflow in a two-stage pipeline.
module fp_exponent_adjust #(
    parameter int EXP_W = 8,
    parameter int BIAS  = 127
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic             norm_inc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic             flag_zero,
    output logic             flag_inf,
    output logic             flag_invalid,
    output logic             flag_ovf,
    output logic             flag_unf
);

    localparam int SW = EXP_W + 2;
    localparam logic [EXP_W-1:0]      ONES    = '1;
    localparam logic signed [SW-1:0]  BIAS_S  = SW'(BIAS);
    localparam logic signed [SW-1:0]  OVF_LIM = SW'((1 << EXP_W) - 1);

    // Handshake: a beat moves across a boundary only when valid && ready on
    // that boundary. A stage accepts when empty or when the stage after it is
    // draining, so bubbles collapse and a full pipe can accept and drain in
    // the same cycle. out_ready -> in_ready is the only combinational path.
    logic w_rdy1;
    logic w_rdy2;

    logic                 r_v1;
    logic                 r_za;
    logic                 r_zb;
    logic                 r_ia;
    logic                 r_ib;
    logic                 r_inc;
    logic signed [SW-1:0] r_sum;

    logic                 r_v2;
    logic [EXP_W-1:0]     r_exp;
    logic                 r_zero;
    logic                 r_inf;
    logic                 r_invalid;
    logic                 r_ovf;
    logic                 r_unf;

    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_e;
    logic [EXP_W-1:0]     w_exp;
    logic                 w_zero;
    logic                 w_inf;
    logic                 w_invalid;
    logic                 w_ovf;
    logic                 w_unf;

    assign w_rdy2   = !r_v2 || out_ready;
    assign w_rdy1   = !r_v1 || w_rdy2;
    assign in_ready = w_rdy1;

    // Two guard bits: one for the carry of a+b, one for the sign after -BIAS.
    assign w_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;
    assign w_e   = r_sum + $signed({{(SW-1){1'b0}}, r_inc});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_za  <= 1'b0;
            r_zb  <= 1'b0;
            r_ia  <= 1'b0;
            r_ib  <= 1'b0;
            r_inc <= 1'b0;
            r_sum <= '0;
        end else if (w_rdy1) begin
            r_v1  <= in_valid;
            r_za  <= (exp_a == '0);
            r_zb  <= (exp_b == '0);
            r_ia  <= (exp_a == ONES);
            r_ib  <= (exp_b == ONES);
            r_inc <= norm_inc;
            r_sum <= w_sum;
        end
    end

    // Priority classification; exactly one rule fires, so flags are one-hot or zero.
    always_comb begin
        w_exp     = w_e[EXP_W-1:0];
        w_zero    = 1'b0;
        w_inf     = 1'b0;
        w_invalid = 1'b0;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        if ((r_za || r_zb) && (r_ia || r_ib)) begin
            w_invalid = 1'b1;
            w_exp     = ONES;
        end else if (r_za || r_zb) begin
            w_zero = 1'b1;
            w_exp  = '0;
        end else if (r_ia || r_ib) begin
            w_inf = 1'b1;
            w_exp = ONES;
        end else if (w_e >= OVF_LIM) begin
            w_ovf = 1'b1;
            w_exp = ONES;
        end else if (w_e[SW-1] || (w_e == '0)) begin
            w_unf = 1'b1;
            w_exp = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2      <= 1'b0;
            r_exp     <= '0;
            r_zero    <= 1'b0;
            r_inf     <= 1'b0;
            r_invalid <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else if (w_rdy2) begin
            r_v2      <= r_v1;
            r_exp     <= w_exp;
            r_zero    <= w_zero;
            r_inf     <= w_inf;
            r_invalid <= w_invalid;
            r_ovf     <= w_ovf;
            r_unf     <= w_unf;
        end
    end

    assign out_valid    = r_v2;
    assign exp_out      = r_exp;
    assign flag_zero    = r_zero;
    assign flag_inf     = r_inf;
    assign flag_invalid = r_invalid;
    assign flag_ovf     = r_ovf;
    assign flag_unf     = r_unf;

endmodule

// File: tb/tb_fp_exponent_adjust.sv
// Directed bench for fp_exponent_adjust: single/double exponent instances,
// boundaries, specials, backpressure and mid-stream reset.
module tb_fp_exponent_adjust;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_ZERO = 5'b10000;
    localparam logic [4:0] F_INF  = 5'b01000;
    localparam logic [4:0] F_INV  = 5'b00100;
    localparam logic [4:0] F_OVF  = 5'b00010;
    localparam logic [4:0] F_UNF  = 5'b00001;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic        norm_inc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic        flag_zero, flag_inf, flag_invalid, flag_ovf, flag_unf;

    logic        in_valid_d;
    logic        in_ready_d;
    logic [10:0] exp_a_d;
    logic [10:0] exp_b_d;
    logic        norm_inc_d;
    logic        out_valid_d;
    logic        out_ready_d;
    logic [10:0] exp_out_d;
    logic        fz_d, fi_d, fv_d, fo_d, fu_d;

    int n_cmp = 0;
    int n_mis = 0;

    // Expected results packed as {zero,inf,invalid,ovf,unf, exponent}.
    logic [15:0] exp_q[$];
    logic [15:0] exp_q_d[$];

    fp_exponent_adjust #(.EXP_W(8), .BIAS(127)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .exp_a(exp_a), .exp_b(exp_b), .norm_inc(norm_inc),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out),
        .flag_zero(flag_zero), .flag_inf(flag_inf), .flag_invalid(flag_invalid),
        .flag_ovf(flag_ovf), .flag_unf(flag_unf)
    );

    fp_exponent_adjust #(.EXP_W(11), .BIAS(1023)) dut_d (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_d), .in_ready(in_ready_d),
        .exp_a(exp_a_d), .exp_b(exp_b_d), .norm_inc(norm_inc_d),
        .out_valid(out_valid_d), .out_ready(out_ready_d),
        .exp_out(exp_out_d),
        .flag_zero(fz_d), .flag_inf(fi_d), .flag_invalid(fv_d),
        .flag_ovf(fo_d), .flag_unf(fu_d)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic inc,
                        input logic [4:0] fl, input logic [7:0] e);
        bit done = 0;
        in_valid = 1'b1; exp_a = a; exp_b = b; norm_inc = inc;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({3'b000, fl, e});
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_cmp++; n_mis++;
            $display("FAIL send_timeout: in_ready stayed 0 for a=%0d b=%0d", a, b);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_d(input logic [10:0] a, input logic [10:0] b, input logic inc,
                          input logic [4:0] fl, input logic [10:0] e);
        bit done = 0;
        in_valid_d = 1'b1; exp_a_d = a; exp_b_d = b; norm_inc_d = inc;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready_d) begin
                exp_q_d.push_back({fl, e});
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_cmp++; n_mis++;
            $display("FAIL send_d_timeout: in_ready stayed 0 for a=%0d b=%0d", a, b);
        end
        in_valid_d = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 50 && (exp_q.size() != 0 || exp_q_d.size() != 0); t++)
            @(posedge clk);
        #1;
        check("drain8", exp_q.size(), 0);
        check("drain11", exp_q_d.size(), 0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_mis++;
                $display("FAIL spurious8: got 0x%0h with no beat outstanding",
                         {flag_zero, flag_inf, flag_invalid, flag_ovf, flag_unf, exp_out});
            end else begin
                check(out_ready ? "out8" : "hold8",
                      {19'd0, flag_zero, flag_inf, flag_invalid, flag_ovf, flag_unf, exp_out},
                      {16'd0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid_d) begin
            if (exp_q_d.size() == 0) begin
                n_cmp++; n_mis++;
                $display("FAIL spurious11: got 0x%0h with no beat outstanding",
                         {fz_d, fi_d, fv_d, fo_d, fu_d, exp_out_d});
            end else begin
                check("out11", {16'd0, fz_d, fi_d, fv_d, fo_d, fu_d, exp_out_d},
                      {16'd0, exp_q_d[0]});
                if (out_ready_d) void'(exp_q_d.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] bp_e[8] = '{8'd123, 8'd124, 8'd125, 8'd126, 8'd127, 8'd128, 8'd129, 8'd130};

    initial begin
        rst_n = 1'b0;
        in_valid = 0; exp_a = 0; exp_b = 0; norm_inc = 0; out_ready = 1;
        in_valid_d = 0; exp_a_d = 0; exp_b_d = 0; norm_inc_d = 0; out_ready_d = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {flag_zero, flag_inf, flag_invalid, flag_ovf, flag_unf, exp_out}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        // Latency: accepted on edge N, visible in cycle N+2.
        send(8'd127, 8'd127, 1'b0, F_NONE, 8'd127);
        @(negedge clk); check("lat_cycle1", out_valid, 0);
        @(negedge clk); check("lat_cycle2", out_valid, 1);
        @(posedge clk); #1;
        send(8'd130, 8'd131, 1'b1, F_NONE, 8'd135);

        // Boundaries and specials, one beat per cycle.
        send(8'd200, 8'd200, 1'b0, F_OVF,  8'd255);
        send(8'd190, 8'd191, 1'b0, F_NONE, 8'd254);
        send(8'd190, 8'd191, 1'b1, F_OVF,  8'd255);
        send(8'd10,  8'd20,  1'b0, F_UNF,  8'd0);
        send(8'd64,  8'd64,  1'b0, F_NONE, 8'd1);
        send(8'd63,  8'd64,  1'b0, F_UNF,  8'd0);
        send(8'd63,  8'd64,  1'b1, F_NONE, 8'd1);
        send(8'd0,   8'd150, 1'b0, F_ZERO, 8'd0);
        send(8'd255, 8'd100, 1'b0, F_INF,  8'd255);
        send(8'd0,   8'd255, 1'b0, F_INV,  8'd255);
        send(8'd255, 8'd0,   1'b1, F_INV,  8'd255);
        send(8'd150, 8'd0,   1'b1, F_ZERO, 8'd0);
        send(8'd255, 8'd255, 1'b0, F_INF,  8'd255);
        wait_drain();

        // Backpressure: out_ready low for four cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(8'(120 + i), 8'd130, 1'b0, F_NONE, bp_e[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with two beats in flight.
        send(8'd140, 8'd140, 1'b0, F_NONE, 8'd153);
        send(8'd140, 8'd141, 1'b0, F_NONE, 8'd154);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_outputs", {flag_zero, flag_inf, flag_invalid, flag_ovf, flag_unf, exp_out}, 0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("mrst_in_ready", in_ready, 1);
        send(8'd100, 8'd50, 1'b1, F_NONE, 8'd24);
        @(negedge clk); check("mrst_lat1", out_valid, 0);
        @(negedge clk); check("mrst_lat2", out_valid, 1);
        wait_drain();

        // Double-precision exponent instance.
        send_d(11'd1023, 11'd1023, 1'b0, F_NONE, 11'd1023);
        send_d(11'd1500, 11'd1600, 1'b0, F_OVF,  11'd2047);
        send_d(11'd2047, 11'd1000, 1'b0, F_INF,  11'd2047);
        send_d(11'd1023, 11'd1024, 1'b1, F_NONE, 11'd1025);
        send_d(11'd500,  11'd523,  1'b0, F_UNF,  11'd0);
        send_d(11'd0,    11'd2047, 1'b0, F_INV,  11'd2047);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
